axil_led_regfile: RTL and testbench

- AXI4-Lite slave (responder) end of the S00_AXI register interface; a master agent drives it with single-beat writes and reads.
- Holds four 32-bit software registers.
- Drives the board LEDs from the registers, with an optional per-LED hardware blink.
- Sits behind the SoC interconnect in the LED peripheral; LED pins go straight to the top-level constraints.

---
 rtl/axil_led_pkg.sv | 23 ++
 rtl/axil_led_blink.sv | 38 +++
 rtl/axil_led_regfile.sv | 181 ++++++++++++++++++
 tb/tb_axil_led_regfile.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/axil_led_pkg.sv
// Shared constants, FSM state types and the byte-strobe merge helper for the LED register block.
package axil_led_pkg;

    localparam logic [1:0] REG_LED      = 2'd0;
    localparam logic [1:0] REG_BLINK_EN = 2'd1;
    localparam logic [1:0] REG_PERIOD   = 2'd2;
    localparam logic [1:0] REG_SCRATCH  = 2'd3;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {W_IDLE, W_WAIT_W, W_WAIT_AW, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;

    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++)
            res[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
        return res;
    endfunction

endpackage

// File: rtl/axil_led_blink.sv
// Blink timebase and registered LED drive: value XOR (phase AND mask), updated one cycle after its inputs.
module axil_led_blink #(
    parameter int NUM_LEDS = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         period,
    input  logic [NUM_LEDS-1:0] mask,
    input  logic [NUM_LEDS-1:0] value,
    output logic [NUM_LEDS-1:0] led_o
);

    logic [31:0] counter;
    logic        phase;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter <= '0;
            phase   <= 1'b0;
            led_o   <= '0;
        end else begin
            if (period == 32'd0) begin
                counter <= '0;
                phase   <= 1'b0;
            end else if (counter == period - 32'd1) begin
                counter <= '0;
                phase   <= ~phase;
            end else if (counter > period - 32'd1) begin
                // period shrank below the running count: restart rather than run to 2^32
                counter <= '0;
            end else begin
                counter <= counter + 32'd1;
            end
            led_o <= value ^ ({NUM_LEDS{phase}} & mask);
        end
    end

endmodule

// File: rtl/axil_led_regfile.sv
// AXI4-Lite responder with four 32-bit registers driving board LEDs with optional hardware blink.
module axil_led_regfile
    import axil_led_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int NUM_LEDS           = 3
) (
    input  logic                              ACLK,
    input  logic                              ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [NUM_LEDS-1:0]               led_o
);

    logic [31:0] regs [4];
    wr_state_t   wr_state;
    rd_state_t   rd_state;
    logic [1:0]  addr_q;
    logic [31:0] data_q;
    logic [3:0]  strb_q;

    logic        aw_hs, w_hs, ar_hs;
    logic        commit;
    logic [1:0]  commit_idx;
    logic [31:0] commit_data;
    logic [3:0]  commit_strb;
    logic        unused_inputs;

    assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID  & S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;

    assign S_AXI_BRESP = RESP_OKAY;
    assign S_AXI_RRESP = RESP_OKAY;

    assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

    // Whichever handshake completes the pair supplies its half; the other half comes from the latch.
    always_comb begin
        commit      = 1'b0;
        commit_idx  = addr_q;
        commit_data = data_q;
        commit_strb = strb_q;
        case (wr_state)
            W_IDLE: if (aw_hs && w_hs) begin
                commit      = 1'b1;
                commit_idx  = S_AXI_AWADDR[3:2];
                commit_data = S_AXI_WDATA;
                commit_strb = S_AXI_WSTRB;
            end
            W_WAIT_W: if (w_hs) begin
                commit      = 1'b1;
                commit_data = S_AXI_WDATA;
                commit_strb = S_AXI_WSTRB;
            end
            W_WAIT_AW: if (aw_hs) begin
                commit      = 1'b1;
                commit_idx  = S_AXI_AWADDR[3:2];
            end
            default: ;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wr_state      <= W_IDLE;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            addr_q        <= '0;
            data_q        <= '0;
            strb_q        <= '0;
        end else begin
            case (wr_state)
                W_IDLE: begin
                    if (commit) begin
                        wr_state      <= W_RESP;
                        S_AXI_AWREADY <= 1'b0;
                        S_AXI_WREADY  <= 1'b0;
                        S_AXI_BVALID  <= 1'b1;
                    end else if (aw_hs) begin
                        wr_state      <= W_WAIT_W;
                        addr_q        <= S_AXI_AWADDR[3:2];
                        S_AXI_AWREADY <= 1'b0;
                        S_AXI_WREADY  <= 1'b1;
                    end else if (w_hs) begin
                        wr_state      <= W_WAIT_AW;
                        data_q        <= S_AXI_WDATA;
                        strb_q        <= S_AXI_WSTRB;
                        S_AXI_AWREADY <= 1'b1;
                        S_AXI_WREADY  <= 1'b0;
                    end else begin
                        S_AXI_AWREADY <= 1'b1;
                        S_AXI_WREADY  <= 1'b1;
                    end
                end
                W_WAIT_W: if (commit) begin
                    wr_state     <= W_RESP;
                    S_AXI_WREADY <= 1'b0;
                    S_AXI_BVALID <= 1'b1;
                end
                W_WAIT_AW: if (commit) begin
                    wr_state      <= W_RESP;
                    S_AXI_AWREADY <= 1'b0;
                    S_AXI_BVALID  <= 1'b1;
                end
                W_RESP: if (S_AXI_BREADY) begin
                    wr_state      <= W_IDLE;
                    S_AXI_BVALID  <= 1'b0;
                    S_AXI_AWREADY <= 1'b1;
                    S_AXI_WREADY  <= 1'b1;
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else if (commit) begin
            regs[commit_idx] <= apply_strb(regs[commit_idx], commit_data, commit_strb);
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rd_state      <= R_IDLE;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        rd_state      <= R_DATA;
                        S_AXI_RDATA   <= regs[S_AXI_ARADDR[3:2]];
                        S_AXI_RVALID  <= 1'b1;
                        S_AXI_ARREADY <= 1'b0;
                    end else begin
                        S_AXI_ARREADY <= 1'b1;
                    end
                end
                R_DATA: if (S_AXI_RREADY) begin
                    rd_state      <= R_IDLE;
                    S_AXI_RVALID  <= 1'b0;
                    S_AXI_ARREADY <= 1'b1;
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    axil_led_blink #(.NUM_LEDS(NUM_LEDS)) u_blink (
        .clk    (ACLK),
        .rst    (ARESET),
        .period (regs[REG_PERIOD]),
        .mask   (regs[REG_BLINK_EN][NUM_LEDS-1:0]),
        .value  (regs[REG_LED][NUM_LEDS-1:0]),
        .led_o  (led_o)
    );

endmodule

// File: tb/tb_axil_led_regfile.sv
// Directed bench for axil_led_regfile: register access, handshake skew, strobes, backpressure, blink and reset.
module tb_axil_led_regfile;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  awaddr = '0, araddr = '0;
    logic [2:0]  awprot = '0, arprot = '0;
    logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic [2:0]  led;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    axil_led_regfile dut (
        .ACLK(clk), .ARESET(rst),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .led_o(led)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input int b_dly);
        int   cyc = 0;
        logic aw_done = 0, w_done = 0, aw_hs, w_hs, early_b = 0, done;
        while (!(aw_done && w_done) && cyc < 40) begin
            if (!aw_done && cyc >= aw_dly) begin awaddr = addr; awvalid = 1; end
            if (!w_done && cyc >= w_dly) begin wdata = data; wstrb = strb; wvalid = 1; end
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(posedge clk); #1;
            cyc++;
            if (aw_hs) begin aw_done = 1; awvalid = 0; end
            if (w_hs)  begin w_done  = 1; wvalid  = 0; end
            if (!(aw_done && w_done) && bvalid) early_b = 1;
        end
        done = aw_done && w_done;
        chk("wr_handshake_done", done, 1);
        chk("wr_bvalid_early", early_b, 0);
        chk("wr_bvalid_latency", bvalid, 1);
        chk("wr_bresp", bresp, 2'b00);
        for (int k = 0; k < b_dly; k++) begin
            @(posedge clk); #1;
            chk("wr_bvalid_hold", bvalid, 1);
            chk("wr_awready_hold", awready, 0);
            chk("wr_wready_hold", wready, 0);
        end
        bready = 1;
        @(posedge clk); #1;
        bready = 0;
        chk("wr_bvalid_clear", bvalid, 0);
    endtask

    task automatic axi_read(input logic [3:0] addr, input logic [31:0] exp, input int r_dly);
        int   cyc = 0;
        logic ar_done = 0, ar_hs;
        while (!ar_done && cyc < 40) begin
            araddr = addr; arvalid = 1;
            ar_hs = arvalid && arready;
            @(posedge clk); #1;
            cyc++;
            if (ar_hs) begin ar_done = 1; arvalid = 0; end
        end
        chk("rd_handshake_done", ar_done, 1);
        chk("rd_rvalid_latency", rvalid, 1);
        chk("rd_rdata", rdata, exp);
        chk("rd_rresp", rresp, 2'b00);
        for (int k = 0; k < r_dly; k++) begin
            @(posedge clk); #1;
            chk("rd_rvalid_hold", rvalid, 1);
            chk("rd_rdata_hold", rdata, exp);
            chk("rd_arready_hold", arready, 0);
        end
        rready = 1;
        @(posedge clk); #1;
        rready = 0;
        chk("rd_rvalid_clear", rvalid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_awready", awready, 0);
        chk("rst_wready", wready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_arready", arready, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_led", led, 0);
        rst = 0;
        @(posedge clk); #1;

        // Basic register map round trip
        for (int i = 0; i < 4; i++) axi_write(4'(i * 4), 32'(i + 1), 4'hF, 0, 0, 0);
        for (int i = 0; i < 4; i++) axi_read(4'(i * 4), 32'(i + 1), 0);

        // W leads AW by 3 cycles, then AW leads W by 3 cycles
        axi_write(4'h0, 32'h0000_0011, 4'hF, 3, 0, 0);
        axi_read(4'h0, 32'h0000_0011, 0);
        axi_write(4'h0, 32'h0000_0022, 4'hF, 0, 3, 0);
        axi_read(4'h0, 32'h0000_0022, 0);

        // Byte strobes on the scratch register
        axi_write(4'hC, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
        axi_write(4'hC, 32'h1234_5678, 4'b0101, 0, 0, 0);
        axi_read(4'hC, 32'hFF34_FF78, 0);

        // Concurrent write and read, both held off by the master for 5 cycles
        fork
            axi_write(4'hC, 32'hCAFE_F00D, 4'hF, 0, 0, 5);
            axi_read(4'h0, 32'h0000_0022, 5);
        join
        axi_read(4'hC, 32'hCAFE_F00D, 0);

        // Blink: stop the timebase, set value/mask, then start with half-period 4
        axi_write(4'h8, 32'd0, 4'hF, 0, 0, 0);
        axi_write(4'h0, 32'h5, 4'hF, 0, 0, 0);
        axi_write(4'h4, 32'h1, 4'hF, 0, 0, 0);
        axi_write(4'h8, 32'd4, 4'hF, 0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("blink_led_%0d", i), led, ((i / 4) % 2) ? 3'b100 : 3'b101);
            @(posedge clk); #1;
        end
        axi_write(4'h8, 32'd0, 4'hF, 0, 0, 0);
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("steady_led_%0d", i), led, 3'b101);
            @(posedge clk); #1;
        end

        // Reset with a write parked in W_WAIT_W and a read response pending
        awaddr = 4'h0; awvalid = 1; araddr = 4'hC; arvalid = 1;
        @(posedge clk); #1;
        awvalid = 0; arvalid = 0;
        chk("pre_rst_rvalid", rvalid, 1);
        chk("pre_rst_rdata", rdata, 32'hCAFE_F00D);
        chk("pre_rst_wready", wready, 1);
        #2 rst = 1;
        #1;
        chk("arst_awready", awready, 0);
        chk("arst_wready", wready, 0);
        chk("arst_bvalid", bvalid, 0);
        chk("arst_arready", arready, 0);
        chk("arst_rvalid", rvalid, 0);
        chk("arst_rdata", rdata, 0);
        chk("arst_led", led, 0);
        repeat (2) @(posedge clk);
        #1 rst = 0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("post_rst_no_bvalid", bvalid, 0);
            chk("post_rst_led", led, 0);
        end
        for (int i = 0; i < 4; i++) axi_read(4'(i * 4), 32'h0, 0);
        axi_write(4'h4, 32'h0000_A5A5, 4'hF, 0, 0, 0);
        axi_read(4'h4, 32'h0000_A5A5, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
